// File: rtl/approx_adder_err_monitor_if.sv
// approx_adder_err_monitor_if: control, sample stream and statistics bundle of the error monitor
interface approx_adder_err_monitor_if #(
  parameter int W     = 8,
  parameter int N_W   = 16,
  parameter int ACC_W = 40
);
  logic             start;
  logic [N_W-1:0]   num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W:0]       in_sum;
  logic             busy;
  logic             done;
  logic [N_W-1:0]   err_count;
  logic [ACC_W-1:0] sum_abs_err;
  logic [ACC_W-1:0] sum_sq_err;
  logic [W:0]       max_abs_err;
  modport master (
    output start, num_samples, in_valid, in_a, in_b, in_sum,
    input  in_ready, busy, done, err_count, sum_abs_err, sum_sq_err, max_abs_err
  );
  modport slave (
    input  start, num_samples, in_valid, in_a, in_b, in_sum,
    output in_ready, busy, done, err_count, sum_abs_err, sum_sq_err, max_abs_err
  );
endinterface

// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor: accumulates mismatch count, |e|, e^2 and max |e| of an approximate adder
module approx_adder_err_monitor #(
  parameter int W     = 8,
  parameter int N_W   = 16,
  parameter int ACC_W = 40
) (
  input logic clk,
  input logic rst,
  approx_adder_err_monitor_if.slave bus
);
  // one spare bit above the wider of accumulator and square flags saturation
  localparam int SW = ((ACC_W > 2*W+2) ? ACC_W : 2*W+2) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic [N_W-1:0]   cnt_q, cnt_d, n_q, n_d, err_q, err_d;
  logic             v_q, v_d, mis_q, mis_d;
  logic [W:0]       abs_q, abs_d, max_q, max_d;
  logic [ACC_W-1:0] sabs_q, sabs_d, ssq_q, ssq_d;
  logic             hs, clr, last;
  logic [W:0]       exact;
  logic [W+1:0]     e;
  logic [2*W+1:0]   sq;
  logic [SW-1:0]    abs_sum, sq_sum;
  assign hs      = bus.in_valid && state_q == RUN;
  assign clr     = state_q == IDLE && bus.start;
  assign last    = hs && (cnt_q + N_W'(1) == n_q);
  assign exact   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign e       = {1'b0, bus.in_sum} - {1'b0, exact};
  assign sq      = {{(W+1){1'b0}}, abs_q} * {{(W+1){1'b0}}, abs_q};
  assign abs_sum = SW'(sabs_q) + SW'(abs_q);
  assign sq_sum  = SW'(ssq_q) + SW'(sq);
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = clr ? '0 : cnt_q + N_W'(hs);
    v_d     = hs;
    mis_d   = hs ? bus.in_sum != exact : mis_q;
    abs_d   = hs ? (e[W+1] ? ~e[W:0] + (W+1)'(1) : e[W:0]) : abs_q;
    err_d   = clr ? '0 : err_q + N_W'(v_q && mis_q);
    sabs_d  = clr ? '0 : !v_q ? sabs_q : |abs_sum[SW-1:ACC_W] ? '1 : abs_sum[ACC_W-1:0];
    ssq_d   = clr ? '0 : !v_q ? ssq_q : |sq_sum[SW-1:ACC_W] ? '1 : sq_sum[ACC_W-1:0];
    max_d   = clr ? '0 : (v_q && abs_q > max_q) ? abs_q : max_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = bus.num_samples == '0 ? DONE : RUN;
        n_d     = bus.num_samples;
      end
      RUN:     state_d = last ? DRAIN : RUN;
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      v_q     <= 1'b0;
      mis_q   <= 1'b0;
      abs_q   <= '0;
      err_q   <= '0;
      sabs_q  <= '0;
      ssq_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      v_q     <= v_d;
      mis_q   <= mis_d;
      abs_q   <= abs_d;
      err_q   <= err_d;
      sabs_q  <= sabs_d;
      ssq_q   <= ssq_d;
      max_q   <= max_d;
    end
  end
  assign bus.in_ready    = state_q == RUN;
  assign bus.busy        = state_q == RUN || state_q == DRAIN;
  assign bus.done        = state_q == DONE;
  assign bus.err_count   = err_q;
  assign bus.sum_abs_err = sabs_q;
  assign bus.sum_sq_err  = ssq_q;
  assign bus.max_abs_err = max_q;
endmodule

// File: doc/approx_adder_err_monitor.md
Name: approx_adder_err_monitor

Overview:
Streaming error-statistics collector that sits on the output side of the 8-bit approximate ripple-carry adders (lower bits approximate, upper bits exact).
- Consumes operand pairs together with the approximate sum the adder under test produced.
- Recomputes the exact sum and accumulates mismatch count, sum of absolute error, sum of squared error and maximum absolute error over a programmed number of samples.
- Feeds the MSE/power characterisation flow: host divides sum_sq_err by num_samples offline.

Parameters:
W, 8, operand width; sums are W+1 bits
N_W, 16, sample-counter width
ACC_W, 40, width of sum_abs_err and sum_sq_err accumulators

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a measurement run; honoured only in IDLE
num_samples  input  N_W  samples to collect; sampled on accepted start
in_valid  input  1  sample present on in_a/in_b/in_sum
in_ready  output  1  monitor accepts a sample this cycle
in_a  input  W  operand 1 (IN1 of adder)
in_b  input  W  operand 2 (IN2 of adder)
in_sum  input  W+1  approximate sum (Out of adder)
busy  output  1  run in progress (RUN or DRAIN)
done  output  1  one-cycle pulse; statistics final
err_count  output  N_W  samples with in_sum != in_a+in_b
sum_abs_err  output  ACC_W  sum of |e|, saturating
sum_sq_err  output  ACC_W  sum of e*e, saturating
max_abs_err  output  W+1  largest |e| seen

Behaviour:
- Error definition: e = in_sum - (in_a + in_b), signed, W+2 bits; |e| <= 2^(W+1)-1, fits W+1 bits; e*e fits 2W+2 bits, zero-extended to ACC_W.
- Reset (async, any state incl. mid-run): state IDLE; in_ready, busy, done = 0; all statistics, sample counter and pipeline valid bits = 0.
- FSM states IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. start=1 with num_samples>0 -> clear all statistics and counter, latch num_samples, go RUN. start=1 with num_samples=0 -> clear statistics, go DONE. Statistics otherwise hold last run's values.
- RUN: in_ready=1 (registered state decode only, no combinational path from in_valid). Handshake = in_valid & in_ready; counter increments per handshake. Handshake bringing counter to num_samples -> DRAIN on that edge. in_valid gaps allowed, no timeout.
- Pipeline: stage 1 registers e, |e|, mismatch flag on the handshake edge; stage 2 updates the accumulators one edge later. One sample per cycle sustained.
- DRAIN: one cycle (stage 2 retires last sample) -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, statistics final -> IDLE. done asserts two cycles after the last handshake cycle.
- busy=1 in RUN and DRAIN only. start while busy or in DONE is ignored.
- Saturation: sum_abs_err and sum_sq_err clamp at all-ones and never wrap. err_count cannot overflow because it is bounded by num_samples.
- max_abs_err updates when the new |e| > current value (strict).
- Inputs are ignored outside RUN handshakes.

Test Plan:
- Single sample, W=8: start, num_samples=1; in_a=0x13, in_b=0x25, in_sum=0x03F (e=+7) -> done 2 cycles after handshake; err_count=1, sum_abs_err=7, sum_sq_err=49, max_abs_err=7.
- Negative error: num_samples=2; (0xFF,0xFF,0x000) then (0x00,0x00,0x000) -> err_count=1, sum_abs_err=510, sum_sq_err=260100, max_abs_err=510.
- Zero samples: start with num_samples=0 -> done on the following cycle; in_ready never 1; all statistics 0.
- Backpressure and ignored start: num_samples=3 of exact sums with in_valid idle 2 cycles between samples; start pulsed mid-run -> exactly 3 handshakes; err_count=0, all sums 0; no restart.
- Saturation: ACC_W=10, num_samples=2, both samples e=-510 -> sum_abs_err=1020 (fits); sum_sq_err=1023 (clamped).
- Reset mid-run: assert rst after 1 of 4 samples -> all outputs 0 immediately. A new run of 1 sample with e=+7 reports only that sample.
